// File: rtl/param_mem_pkg.sv
// rtl/param_mem_pkg.sv - shared types, constants and byte-lane merge for param_mem
package param_mem_pkg;

    typedef enum logic {ST_CLEAR, ST_READY} pmem_state_t;

    localparam int BYTE_W = 8;

    // One byte lane of a byte-enable merge; callers replicate it across lanes
    function automatic logic [BYTE_W-1:0] merge_be(
        input logic [BYTE_W-1:0] old_b,
        input logic [BYTE_W-1:0] new_b,
        input logic              be
    );
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/param_mem_core.sv
// rtl/param_mem_core.sv - storage array with byte-enable write and raw asynchronous read
module param_mem_core
    import param_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [IDX_W-1:0]         i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [DATA_W/BYTE_W-1:0] i_wbe,
    input  logic [IDX_W-1:0]         i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    localparam int NB = DATA_W / BYTE_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_new;

    assign w_old = r_mem[i_waddr];

    for (genvar g = 0; g < NB; g++) begin : g_lane
        assign w_new[g*BYTE_W +: BYTE_W] = merge_be(w_old[g*BYTE_W +: BYTE_W],
                                                    i_wdata[g*BYTE_W +: BYTE_W],
                                                    i_wbe[g]);
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= w_new;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_mem.sv
// rtl/param_mem.sv - simple-dual-port RAM with zero-fill, byte enables, range check and forwarding
module param_mem
    import param_mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/BYTE_W-1:0] wbe,
    input  logic                     ren,
    input  logic [ADDR_W-1:0]        raddr,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic                     ready,
    output logic                     err,
    input  logic                     err_clr
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    pmem_state_t       r_state;
    pmem_state_t       w_state_nxt;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic              r_err;

    logic              w_ready;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_rd_acc;
    logic              w_core_we;
    logic [IDX_W-1:0]  w_core_waddr;
    logic [DATA_W-1:0] w_core_wdata;
    logic [NB-1:0]     w_core_wbe;
    logic [DATA_W-1:0] w_core_rdata;

    assign w_ready  = (r_state == ST_READY);
    assign w_wr_ok  = (waddr < DEPTH_A);
    assign w_rd_ok  = (raddr < DEPTH_A);
    assign w_rd_acc = ren && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_CLEAR: begin
                if (r_ptr == LAST_IDX) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // During the fill the clear pointer owns the write port; user writes are masked
    always_comb begin
        w_core_we    = 1'b1;
        w_core_waddr = r_ptr;
        w_core_wdata = '0;
        w_core_wbe   = '1;
        if (w_ready) begin
            w_core_we    = wen && w_wr_ok;
            w_core_waddr = waddr[IDX_W-1:0];
            w_core_wdata = wdata;
            w_core_wbe   = wbe;
        end
    end

    param_mem_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_core (
        .clk     (clk),
        .i_we    (w_core_we),
        .i_waddr (w_core_waddr),
        .i_wdata (w_core_wdata),
        .i_wbe   (w_core_wbe),
        .i_raddr (raddr[IDX_W-1:0]),
        .o_rdata (w_core_rdata)
    );

    // A fresh violation outranks a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_ready && ((wen && !w_wr_ok) || (ren && !w_rd_ok))) begin
            r_err <= 1'b1;
        end else if (w_ready && err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign ready = w_ready;
    assign err   = r_err;

    if (RD_LAT == 0) begin : g_comb_rd
        assign rvalid = w_rd_acc;
        assign rdata  = (w_rd_acc && w_rd_ok) ? w_core_rdata : '0;
    end else begin : g_reg_rd
        logic              w_fwd;
        logic [DATA_W-1:0] w_fwd_word;
        logic [DATA_W-1:0] w_rd_word;
        logic [DATA_W-1:0] r_rdata;
        logic              r_rvalid;

        assign w_fwd = (WR_FIRST != 0) && wen && w_wr_ok && (waddr == raddr);

        for (genvar g = 0; g < NB; g++) begin : g_fwd_lane
            assign w_fwd_word[g*BYTE_W +: BYTE_W] = merge_be(w_core_rdata[g*BYTE_W +: BYTE_W],
                                                             wdata[g*BYTE_W +: BYTE_W],
                                                             wbe[g]);
        end

        assign w_rd_word = !w_rd_ok ? '0 : (w_fwd ? w_fwd_word : w_core_rdata);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rdata  <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_rdata <= w_rd_word;
                end
            end
        end

        assign rvalid = r_rvalid;
        assign rdata  = r_rdata;
    end

endmodule

// File: tb/tb_param_mem.sv
// tb/tb_param_mem.sv - scoreboard bench for param_mem in three latency/ordering configurations
module tb_param_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        ren;
    logic [7:0]  raddr;
    logic        err_clr;

    logic [31:0] rd1, rdf, rd0;
    logic        rv1, rvf, rv0;
    logic        rdy1, rdyf, rdy0;
    logic        er1, erf, er0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q1[$];
    logic [31:0] qf[$];
    logic [31:0] q0[$];

    always #5 clk = ~clk;

    param_mem #(.DATA_W(32), .DEPTH(16), .ADDR_W(8), .RD_LAT(1), .WR_FIRST(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .rdata(rd1), .rvalid(rv1), .ready(rdy1), .err(er1),
        .err_clr(err_clr));

    param_mem #(.DATA_W(32), .DEPTH(16), .ADDR_W(8), .RD_LAT(1), .WR_FIRST(0)) dut_wf0 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .rdata(rdf), .rvalid(rvf), .ready(rdyf), .err(erf),
        .err_clr(err_clr));

    param_mem #(.DATA_W(32), .DEPTH(16), .ADDR_W(8), .RD_LAT(0), .WR_FIRST(1)) dut_l0 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .rdata(rd0), .rvalid(rv0), .ready(rdy0), .err(er0),
        .err_clr(err_clr));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected word whenever a DUT presents rvalid
    always @(negedge clk) begin
        if (rv1) begin
            if (q1.size() == 0) check("l1_unexpected_rvalid", 32'd1, 32'd0);
            else check("l1_rdata", rd1, q1.pop_front());
        end
        if (rvf) begin
            if (qf.size() == 0) check("wf0_unexpected_rvalid", 32'd1, 32'd0);
            else check("wf0_rdata", rdf, qf.pop_front());
        end
        if (rv0) begin
            if (q0.size() == 0) check("l0_unexpected_rvalid", 32'd1, 32'd0);
            else check("l0_rdata", rd0, q0.pop_front());
        end
    end

    task automatic step(input logic w, input logic [7:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic r, input logic [7:0] ra,
                        input logic [31:0] e1, input logic [31:0] ef, input logic [31:0] e0,
                        input logic clr);
        wen = w; waddr = wa; wdata = wd; wbe = be;
        ren = r; raddr = ra; err_clr = clr;
        if (r) begin
            q1.push_back(e1);
            qf.push_back(ef);
            q0.push_back(e0);
        end
        @(posedge clk); #1;
        wen = 1'b0; ren = 1'b0; err_clr = 1'b0; wbe = 4'h0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        step(1'b0, 8'd0, 32'd0, 4'h0, 1'b1, a, e, e, e, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b1, a, d, be, 1'b0, 8'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    int cyc;

    initial begin
        rst_n = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        ren = 1'b0; raddr = '0; err_clr = 1'b0;
        #3;
        check("reset_rdata", rd1, 32'd0);
        check("reset_rvalid", {31'd0, rv1}, 32'd0);
        check("reset_ready", {29'd0, rdy1, rdyf, rdy0}, 32'd0);
        check("reset_err", {31'd0, er1}, 32'd0);

        // Reset mid-clear with ports busy throughout the fill
        @(posedge clk); #1;
        rst_n = 1'b1;
        wen = 1'b1; waddr = 8'd3; wdata = 32'hDEADBEEF; wbe = 4'hF;
        ren = 1'b1; raddr = 8'd20; err_clr = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("midclear_ready", {31'd0, rdy1}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midclear_rst_ready", {31'd0, rdy1}, 32'd0);
        rst_n = 1'b1;
        cyc = 0;
        while (!rdy1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        wen = 1'b0; ren = 1'b0; err_clr = 1'b0; wbe = 4'h0;
        check("fill_cycles", cyc, 32'd16);
        check("fill_ready_all", {29'd0, rdy1, rdyf, rdy0}, 32'h7);
        check("fill_err", {29'd0, er1, erf, er0}, 32'd0);
        check("fill_rvalid", {30'd0, rv1, rvf}, 32'd0);

        for (int i = 0; i < 16; i++) rd(8'(i), 32'd0);

        // Byte enables
        wr(8'd3, 32'hAABBCCDD, 4'hF);
        wr(8'd3, 32'h11223344, 4'b0101);
        rd(8'd3, 32'hAA22CC44);
        check("rvalid_after_read", {31'd0, rv1}, 32'd1);
        @(posedge clk); #1;
        check("rvalid_pulse", {31'd0, rv1}, 32'd0);
        check("rdata_hold", rd1, 32'hAA22CC44);
        check("l0_idle_rdata", rd0, 32'd0);
        check("l0_idle_rvalid", {31'd0, rv0}, 32'd0);

        // Read-during-write, full and partial lanes
        wr(8'd5, 32'h1, 4'hF);
        step(1'b1, 8'd5, 32'h2, 4'hF, 1'b1, 8'd5, 32'h2, 32'h1, 32'h1, 1'b0);
        rd(8'd5, 32'h2);
        step(1'b1, 8'd3, 32'h55667788, 4'b1000, 1'b1, 8'd3,
             32'h5522CC44, 32'hAA22CC44, 32'hAA22CC44, 1'b0);
        rd(8'd3, 32'h5522CC44);

        // Independent write and read at different addresses
        step(1'b1, 8'd7, 32'hCAFEF00D, 4'hF, 1'b1, 8'd5, 32'h2, 32'h2, 32'h2, 1'b0);
        rd(8'd7, 32'hCAFEF00D);

        // Out of range
        check("err_before_range", {29'd0, er1, erf, er0}, 32'd0);
        wr(8'd20, 32'h12345678, 4'hF);
        check("err_after_bad_write", {29'd0, er1, erf, er0}, 32'h7);
        rd(8'd20, 32'd0);
        rd(8'd4, 32'd0);
        check("err_sticky", {31'd0, er1}, 32'd1);
        step(1'b0, 8'd0, 32'd0, 4'h0, 1'b0, 8'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        check("err_cleared", {29'd0, er1, erf, er0}, 32'd0);
        step(1'b0, 8'd0, 32'd0, 4'h0, 1'b1, 8'd20, 32'd0, 32'd0, 32'd0, 1'b1);
        check("err_set_wins", {29'd0, er1, erf, er0}, 32'h7);

        repeat (3) @(posedge clk);
        #1;
        check("queues_drained", q1.size() + qf.size() + q0.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_mem.md
Name: param_mem

Overview:
Parametrised simple-dual-port RAM: one write port, one read port, shared clock.
- Adds byte-enable writes, selectable read latency, defined read-during-write ordering, out-of-range detection, and hardware zero-fill after reset.
- Used as the general scratch and buffer memory for datapath blocks that need a known-clean array after reset.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words; any value ≥2, not required to be a power of two.
- ADDR_W, 32, address port width; must be ≥ $clog2(DEPTH).
- RD_LAT, 1, read latency: 0 = combinational read, 1 = registered read.
- WR_FIRST, 1, same-address read-during-write: 1 returns new data, 0 returns old data.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wen  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- wbe  in  DATA_W/8  byte enables; bit i enables wdata[8i+7:8i]
- ren  in  1  read enable
- raddr  in  ADDR_W  read address
- rdata  out  DATA_W  read data
- rvalid  out  1  rdata valid strobe
- ready  out  1  zero-fill done; ports accepted only when high
- err  out  1  sticky out-of-range flag
- err_clr  in  1  clears err

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: rdata=0, rvalid=0, ready=0, err=0, FSM=ST_CLEAR, clear pointer=0. The array itself is not reset by rst_n.
- FSM, ST_CLEAR:
  - Writes all-zero to address ptr each cycle, then ptr++.
  - When ptr==DEPTH-1 is written, next state is ST_READY. Zero-fill takes exactly DEPTH cycles after rst_n deasserts.
  - wen, ren and err_clr are ignored. rvalid=0, ready=0.
- FSM, ST_READY: ready=1. Stays in ST_READY until rst_n asserts.
- Reset mid-clear: rst_n low forces ST_CLEAR and ptr=0; the fill restarts from 0 on release.
- Write (ST_READY, wen=1, waddr<DEPTH): each byte lane with wbe[i]=1 is updated at the clock edge. Lanes with wbe[i]=0 keep their old value. wbe=0 is a legal no-op.
- Read, RD_LAT=1: ren sampled at edge N gives rdata and rvalid=1 after edge N.
- Read, RD_LAT=0: rdata is a combinational view of the array and rvalid=ren&ready in the same cycle.
- rvalid with RD_LAT=1: one-cycle pulse per accepted read.
- rdata when not reading: holds its last value, never Z. In RD_LAT=0, rdata=0 when ren=0.
- Read-during-write, same address:
  - WR_FIRST=1: rdata = old word with the enabled bytes replaced by wdata.
  - WR_FIRST=0: rdata = pre-write word.
  - RD_LAT=0 always shows the pre-edge array contents.
- Out of range (addr ≥ DEPTH):
  - Write: dropped.
  - Read: still completes with rvalid per latency and rdata=0.
  - Either case sets err on the next edge.
- err_clr: clears err. If a new violation occurs in the same cycle, the set wins.
- Simultaneous wen and ren at different addresses: both proceed independently.

Decomposition:
- Package param_mem_pkg:
  - typedef enum logic {ST_CLEAR, ST_READY} pmem_state_t
  - localparam byte width 8
  - function merge_be(old, new, be) for byte-lane merge, shared by the write path and forwarding
- Sub-module param_mem_core:
  - Holds the storage array, byte-enable write and raw read.
  - Its write port is muxed by the top between the clear pointer and the user port.
- The top holds the FSM, range checks, forwarding, the output register and err.

Test Plan:
- Fill: release rst_n, DEPTH=16 → ready rises after exactly 16 cycles. Reads of addresses 0..15 then return 0x00000000.
- Byte enables: write 0xAABBCCDD, wbe=4'hF, to addr 3; then write 0x11223344 with wbe=4'b0101 → read addr 3 returns 0xAA22CC44, rvalid one cycle after ren (RD_LAT=1).
- Read-during-write: addr 5 holds 0x1; same cycle wen=1 wdata=0x2 wbe=F, ren=1 raddr=5 → rdata=0x2 with WR_FIRST=1, 0x1 with WR_FIRST=0. The next read returns 0x2 in both cases.
- Range: DEPTH=16, write to addr 20, then read addr 20 → write dropped, rdata=0, err=1 and stays 1. Pulse err_clr → err=0. err_clr together with a new bad read → err stays 1.
- Reset mid-clear: assert rst_n low at clear cycle 7 of 16 → ready stays 0 and the fill restarts. ready rises 16 cycles after release. Ports asserted during the fill have no effect and rvalid stays 0.
- RD_LAT=0: ren=1 raddr=3 → rdata valid in the same cycle, rvalid=1 combinationally. ren=0 → rdata=0.
